bus_dma_arbiter: RTL
====================

# bus_dma_arbiter

Owns the shared Game Boy memory bus (address_bus, nread, nwrite, nsel, data) between the CPU and the OAM DMA engine. A CPU write to 0xFF46 launches a 160-byte copy from page XX00 into OAM at 0xFE00. While the copy runs, the block sequences the ROM/RAM/OAM devices and fences off the CPU. It sits between the CPU core and the address decoder that feeds memory_rom and the other bus devices.

## Interface
Parameters:
- DMA_LENGTH, 160, bytes per transfer
- DMA_DEST, 16'hFE00, OAM base address
- DMA_REG_ADDR, 16'hFF46, trigger register address

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- cpu_address  in  16  CPU address
- cpu_nread  in  1  CPU read strobe, active-low
- cpu_nwrite  in  1  CPU write strobe, active-low
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  data returned to CPU
- cpu_blocked  out  1  high while DMA owns the bus
- address_bus  out  16  bus address
- nread  out  1  bus read strobe, active-low
- nwrite  out  1  bus write strobe, active-low
- nsel  out  1  low when nread or nwrite is low
- bus_rdata  in  8  data from selected device
- bus_wdata  out  8  data to devices
- bus_wdata_oe  out  1  high when bus_wdata is valid (drives external tri-state)

## Operation
- States: IDLE, SETUP, READ, WRITE.
- IDLE: bus outputs pass the CPU signals through combinationally. address_bus=cpu_address, nread=cpu_nread, nwrite=cpu_nwrite, bus_wdata=cpu_wdata, bus_wdata_oe=~cpu_nwrite, cpu_rdata=bus_rdata.
- Trigger: a CPU write (cpu_nwrite=0) to DMA_REG_ADDR latches src_page=cpu_wdata and clears index to 0. It also goes out on the bus in IDLE. Next state is SETUP.
- SETUP: one idle bus cycle with all strobes high, then READ.
- READ: address_bus={src_page,8'h00}+index, nread=0; bus_rdata is latched into data_hold at the clock edge. Next state is WRITE.
- WRITE: address_bus=DMA_DEST+index, nwrite=0, bus_wdata=data_hold, bus_wdata_oe=1, then index+1.
  - If the new index equals DMA_LENGTH, next state is IDLE.
  - Otherwise next state is READ.
- index is 8-bit. Source address arithmetic is 16-bit with no wrap out of the page, since index ≤ 159.
- In SETUP, READ and WRITE:
  - cpu_blocked=1.
  - CPU reads return 8'hFF.
  - CPU writes are discarded, except writes to DMA_REG_ADDR.
- A CPU write to DMA_REG_ADDR during DMA restarts the transfer. It reloads src_page, clears index and goes to SETUP. Restart wins over the normal WRITE→READ/IDLE transition in the same cycle.
- Source page 0xFE or above is accepted unchanged; no clamping.
- Reset, including mid-transfer, forces IDLE with index=0, src_page=0 and data_hold=0. No partial byte completes.

## Timing
- Reset outputs: cpu_blocked=0; bus outputs follow the CPU passthrough; strobes high when the CPU is idle.
- In DMA states all outputs are decoded from registered state only. The CPU path is combinational only in IDLE.
- Trigger write at edge N: SETUP during cycle N+1, first READ at cycle N+2.
- 2 cycles per byte. Total busy time is 1+2·DMA_LENGTH = 321 cycles.
- cpu_blocked falls in the cycle after the final WRITE.
- nsel = nread & nwrite in every state.

## Configuration
- Macro: BUS_DMA_REG_READBACK_EN.
  - Defined: a CPU read of DMA_REG_ADDR returns src_page from this block in any state, and the bus is not strobed for that read.
  - Undefined: the read is treated like any other address: passed to the bus in IDLE, and returns 8'hFF during DMA.

## Structure
- Shared package gb_bus_pkg holds:
  - the state enum (IDLE/SETUP/READ/WRITE)
  - DMA_REG_ADDR, OAM_BASE and OAM_SIZE constants
  - the HRAM range constants used by later blocks
- Sub-module oam_dma_engine holds the FSM, index counter, src_page and data_hold, and produces the DMA-side bus request.
- Top-level bus_dma_arbiter muxes the CPU and DMA sides and applies CPU blocking.

## Test plan
- Passthrough: IDLE, CPU read 0x0000 with ROM byte 0xAB → address_bus=0x0000, nread=0, nsel=0, cpu_rdata=0xAB, cpu_blocked=0.
- Full transfer: write 0xC1 to 0xFF46 →
  - first READ at 0xC100 two cycles later, first WRITE to 0xFE00 carrying the read byte;
  - last WRITE to 0xFE9F with data from 0xC19F;
  - cpu_blocked high for exactly 321 cycles.
- Blocking: CPU read 0x0010 mid-DMA → cpu_rdata=0xFF, bus shows the DMA address. CPU write to 0xC000 mid-DMA → no nwrite with address 0xC000.
- Restart: write 0xC2 to 0xFF46 at byte index 50 → SETUP, then READ at 0xC200, index restarts at 0, a full 160 bytes follow.
- Reset mid-transfer: assert reset at index 80 → next cycle IDLE, cpu_blocked=0, no further DMA strobes, a subsequent CPU read passes through.
- Readback (BUS_DMA_REG_READBACK_EN defined): write 0x80 to 0xFF46, read 0xFF46 during DMA → cpu_rdata=0x80, no bus strobe for that read.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared Game Boy bus definitions: DMA FSM states, register and memory-map constants.
// Used by the bus arbiter, the OAM DMA engine and later bus devices (HRAM range).
package gb_bus_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_SETUP = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_e;

    localparam logic [1:0] ST_IDLE  = DMA_IDLE;
    localparam logic [1:0] ST_SETUP = DMA_SETUP;
    localparam logic [1:0] ST_READ  = DMA_READ;
    localparam logic [1:0] ST_WRITE = DMA_WRITE;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_SIZE     = 160;

    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] HRAM_LAST    = 16'hFFFE;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: FSM, byte index, source page and read-data hold; issues the DMA-side bus request.
// Latency: trigger at edge N -> SETUP in N+1, first READ in N+2, then 2 cycles per byte.
// Backpressure: none; the engine owns the bus while busy and a new trigger restarts it.
module oam_dma_engine
    import gb_bus_pkg::*;
#(
    parameter int          DMA_LENGTH = OAM_SIZE,
    parameter logic [15:0] DMA_DEST   = OAM_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [7:0]  trigger_page,
    input  logic [7:0]  bus_rdata,
    output logic        busy,
    output logic [7:0]  src_page,
    output logic [15:0] dma_address,
    output logic        dma_nread,
    output logic        dma_nwrite,
    output logic [7:0]  dma_wdata,
    output logic        dma_wdata_oe
);

    logic [1:0] state;
    logic [7:0] index;
    logic [7:0] data_hold;
    logic       last_byte;

    // Compared one bit wider so a full 256-byte length would still terminate.
    assign last_byte = (({1'b0, index} + 9'd1) == 9'(DMA_LENGTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            index     <= 8'd0;
            src_page  <= 8'd0;
            data_hold <= 8'd0;
        end else if (trigger) begin
            state    <= ST_SETUP;
            index    <= 8'd0;
            src_page <= trigger_page;
        end else begin
            case (state)
                ST_SETUP: state <= ST_READ;
                ST_READ: begin
                    data_hold <= bus_rdata;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    index <= index + 8'd1;
                    state <= last_byte ? ST_IDLE : ST_READ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_address  = {src_page, 8'h00} + {8'h00, index};
        dma_nread    = 1'b1;
        dma_nwrite   = 1'b1;
        dma_wdata    = data_hold;
        dma_wdata_oe = 1'b0;
        case (state)
            ST_READ:  dma_nread = 1'b0;
            ST_WRITE: begin
                dma_address  = DMA_DEST + {8'h00, index};
                dma_nwrite   = 1'b0;
                dma_wdata_oe = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/bus_dma_arbiter.sv
// Shared-bus arbiter between the CPU and the OAM DMA engine; optional macro BUS_DMA_REG_READBACK_EN.
// Latency: CPU path is combinational in IDLE; during DMA all bus outputs come from engine registers.
// Backpressure: cpu_blocked high while DMA runs; CPU reads return 8'hFF and CPU writes are dropped.
module bus_dma_arbiter #(
    parameter int          DMA_LENGTH   = gb_bus_pkg::OAM_SIZE,
    parameter logic [15:0] DMA_DEST     = gb_bus_pkg::OAM_BASE,
    parameter logic [15:0] DMA_REG_ADDR = gb_bus_pkg::DMA_REG_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic        cpu_nread,
    input  logic        cpu_nwrite,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_blocked,
    output logic [15:0] address_bus,
    output logic        nread,
    output logic        nwrite,
    output logic        nsel,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  bus_wdata,
    output logic        bus_wdata_oe
);

    import gb_bus_pkg::*;

    logic        reg_hit;
    logic        trigger;
    logic        readback_rd;
    logic        busy;
    logic [7:0]  src_page;
    logic [15:0] dma_address;
    logic        dma_nread;
    logic        dma_nwrite;
    logic [7:0]  dma_wdata;
    logic        dma_wdata_oe;

    assign reg_hit = (cpu_address == DMA_REG_ADDR);
    // Trigger writes are honoured in every state, which is what makes mid-transfer restart work.
    assign trigger = reg_hit & ~cpu_nwrite;

`ifdef BUS_DMA_REG_READBACK_EN
    assign readback_rd = reg_hit & ~cpu_nread;
`else
    assign readback_rd = 1'b0;
`endif

    oam_dma_engine #(
        .DMA_LENGTH (DMA_LENGTH),
        .DMA_DEST   (DMA_DEST)
    ) u_engine (
        .clock        (clock),
        .reset        (reset),
        .trigger      (trigger),
        .trigger_page (cpu_wdata),
        .bus_rdata    (bus_rdata),
        .busy         (busy),
        .src_page     (src_page),
        .dma_address  (dma_address),
        .dma_nread    (dma_nread),
        .dma_nwrite   (dma_nwrite),
        .dma_wdata    (dma_wdata),
        .dma_wdata_oe (dma_wdata_oe)
    );

    always_comb begin
        if (busy) begin
            address_bus  = dma_address;
            nread        = dma_nread;
            nwrite       = dma_nwrite;
            bus_wdata    = dma_wdata;
            bus_wdata_oe = dma_wdata_oe;
            cpu_rdata    = readback_rd ? src_page : 8'hFF;
        end else begin
            address_bus  = cpu_address;
            nread        = cpu_nread | readback_rd;
            nwrite       = cpu_nwrite;
            bus_wdata    = cpu_wdata;
            bus_wdata_oe = ~cpu_nwrite;
            cpu_rdata    = readback_rd ? src_page : bus_rdata;
        end
    end

    assign nsel        = nread & nwrite;
    assign cpu_blocked = busy;

endmodule
